// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the streaming descending sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Counter width for indexing n entries; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare-exchange element: larger value to hi_out, smaller to lo_out.
module sort_cmp_swap #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic swap_s;

  // Strict less-than keeps equal values in place.
  assign swap_s = (hi_in < lo_in);
  assign hi_out = swap_s ? lo_in : hi_in;
  assign lo_out = swap_s ? hi_in : lo_in;

endmodule

// File: rtl/sort_stream.sv
// Streaming block sorter: load NUM_VALS values, odd-even transposition sort
// in NUM_VALS passes, then drain them largest first.
module sort_stream
  import sort_pkg::*;
#(
  parameter int NUM_VALS = 8,
  parameter int WIDTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int            CW       = cnt_width(NUM_VALS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VALS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    load_q, load_d;
  logic [CW-1:0]    pass_q, pass_d;
  logic [CW-1:0]    drain_q, drain_d;
  logic [WIDTH-1:0] mem_q [NUM_VALS];
  logic [WIDTH-1:0] mem_d [NUM_VALS];
  logic [WIDTH-1:0] hi_s [NUM_VALS-1];
  logic [WIDTH-1:0] lo_s [NUM_VALS-1];

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  genvar g;
  generate
    for (g = 0; g < NUM_VALS - 1; g++) begin : g_cmp
      sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
        .hi_in  (mem_q[g]),
        .lo_in  (mem_q[g+1]),
        .hi_out (hi_s[g]),
        .lo_out (lo_s[g])
      );
    end
  endgenerate

  // Next-state, storage update and next output values.
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    pass_d  = pass_q;
    drain_d = drain_q;
    mem_d   = mem_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[load_q] = in_data;
          if (load_q == LAST_IDX) begin
            state_d = ST_SORT;
            load_d  = '0;
            pass_d  = '0;
          end else begin
            load_d = load_q + 1'b1;
          end
        end else begin
          load_d = load_q;
        end
      end
      ST_SORT: begin
        // Pairs of one parity are disjoint, so sequential overwrite is safe.
        for (int k = 0; k < NUM_VALS - 1; k++) begin
          mem_d[k]   = ((k % 2) == int'(pass_q[0])) ? hi_s[k] : mem_d[k];
          mem_d[k+1] = ((k % 2) == int'(pass_q[0])) ? lo_s[k] : mem_d[k+1];
        end
        if (pass_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          pass_d  = '0;
          drain_d = '0;
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (drain_q == LAST_IDX) begin
            state_d = ST_LOAD;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end else begin
          drain_d = drain_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        load_d  = '0;
        pass_d  = '0;
        drain_d = '0;
      end
    endcase

    in_ready_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
    if (state_d == ST_DRAIN) begin
      out_data_d = mem_d[drain_d];
      out_last_d = (drain_d == LAST_IDX);
    end else begin
      out_data_d = '0;
      out_last_d = 1'b0;
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      load_q      <= '0;
      pass_q      <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      pass_q      <= pass_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Value storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sort_stream.sv
// Self-checking bench for sort_stream: directed blocks, randomized blocks
// against a selection-sort reference, handshake stress and mid-run resets.
module tb_sort_stream;

  localparam int N = 8;
  localparam int W = 4;

  typedef logic [W-1:0] blk_t [N];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  sort_stream #(.NUM_VALS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] got_d [$];
  bit           got_l [$];
  int first_valid_cyc, last_acc_cyc;
  int stab_err, rdy_err, zero_err;
  bit timeout, rdy_after;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic blk_t model_sort(input blk_t v);
    blk_t b;
    logic [W-1:0] t;
    b = v;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (b[j] > b[i]) begin
          t = b[i]; b[i] = b[j]; b[j] = t;
        end
    return b;
  endfunction

  task automatic clear_flags();
    stab_err = 0; rdy_err = 0; zero_err = 0; timeout = 1'b0;
  endtask

  task automatic load_n(input blk_t v, input int n, input bit gaps);
    int i;
    int guard;
    bit rdy;
    i = 0;
    guard = 0;
    while (i < n && guard < 500) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = v[i];
      end
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        i++;
        last_acc_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (i < n) timeout = 1'b1;
  endtask

  task automatic drain_n(input int n, input bit stall);
    int k, guard, ph;
    bit pv, pr, pl;
    logic [W-1:0] pd;
    k = 0; guard = 0; ph = 0; pv = 0; pr = 1; pl = 0; pd = '0;
    got_d.delete();
    got_l.delete();
    first_valid_cyc = -1;
    while (k < n && guard < 300) begin
      guard++;
      out_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      if (in_ready !== 1'b0) rdy_err++;
      if (!out_valid && out_data !== '0) zero_err++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && pv && !pr && (out_data !== pd || out_last !== pl)) stab_err++;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      @(posedge clk); #1;
      if (pv && pr) begin
        got_d.push_back(pd);
        got_l.push_back(pl);
        k++;
      end
    end
    out_ready = 1'b0;
    if (k < n) timeout = 1'b1;
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_tests++;
    if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    blk_t ins [5];
    blk_t exps [5];
    ins[0] = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
    exps[0] = '{4'h9, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h1};
    ins[1] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    exps[1] = '{4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    ins[2] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    exps[2] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
    ins[3] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    exps[3] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
    ins[4] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    exps[4] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int b = 0; b < 5; b++) begin
      clear_flags();
      load_n(ins[b], N, 1'b0);
      drain_n(N, 1'b0);
      n_tests++;
      if (timeout || got_d.size() != N) begin
        n_fail++; $display("FAIL pattern%0d_count: got %0d outputs timeout=%0b want %0d", b, got_d.size(), timeout, N);
      end
      n_tests++;
      if (first_valid_cyc - last_acc_cyc != N) begin
        n_fail++; $display("FAIL pattern%0d_latency: got %0d want %0d", b, first_valid_cyc - last_acc_cyc, N);
      end
      for (int i = 0; i < N && i < got_d.size(); i++) begin
        n_tests++;
        if (got_d[i] !== exps[b][i] || got_l[i] !== (i == N - 1)) begin
          n_fail++;
          $display("FAIL pattern%0d_out%0d: got %h last=%0b want %h last=%0b", b, i, got_d[i], got_l[i], exps[b][i], i == N - 1);
        end
      end
    end
  endtask

  task automatic test_random();
    blk_t v, e;
    bit st;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 15));
      e = model_sort(v);
      st = 1'($urandom_range(0, 1));
      clear_flags();
      load_n(v, N, 1'b1);
      drain_n(N, st);
      n_tests++;
      if (timeout || got_d.size() != N || stab_err != 0 || rdy_err != 0 || zero_err != 0) begin
        n_fail++;
        $display("FAIL random%0d_protocol: outputs=%0d timeout=%0b stab=%0d rdy=%0d zero=%0d want 8/0/0/0/0", b, got_d.size(), timeout, stab_err, rdy_err, zero_err);
      end
      n_tests++;
      if (first_valid_cyc - last_acc_cyc != N) begin
        n_fail++; $display("FAIL random%0d_latency: got %0d want %0d", b, first_valid_cyc - last_acc_cyc, N);
      end
      for (int i = 0; i < N && i < got_d.size(); i++) begin
        n_tests++;
        if (got_d[i] !== e[i] || got_l[i] !== (i == N - 1)) begin
          n_fail++;
          $display("FAIL random%0d_out%0d: got %h last=%0b want %h last=%0b", b, i, got_d[i], got_l[i], e[i], i == N - 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    blk_t v, e;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 15));
      e = model_sort(v);
      clear_flags();
      load_n(v, N, 1'b1);
      drain_n(N, 1'b1);
      n_tests++;
      if (timeout || got_d.size() != N) begin
        n_fail++; $display("FAIL b2b%0d_count: got %0d timeout=%0b want %0d", b, got_d.size(), timeout, N);
      end
      n_tests++;
      if (stab_err != 0) begin n_fail++; $display("FAIL b2b%0d_stall_stable: got %0d changes want 0", b, stab_err); end
      n_tests++;
      if (rdy_err != 0) begin n_fail++; $display("FAIL b2b%0d_in_ready_busy: got %0d high cycles want 0", b, rdy_err); end
      n_tests++;
      if (zero_err != 0) begin n_fail++; $display("FAIL b2b%0d_idle_data: got %0d nonzero want 0", b, zero_err); end
      n_tests++;
      if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_ready_after: got %b want 1", b, rdy_after); end
      for (int i = 0; i < N && i < got_d.size(); i++) begin
        n_tests++;
        if (got_d[i] !== e[i] || got_l[i] !== (i == N - 1)) begin
          n_fail++;
          $display("FAIL b2b%0d_out%0d: got %h last=%0b want %h last=%0b", b, i, got_d[i], got_l[i], e[i], i == N - 1);
        end
      end
    end
  endtask

  task automatic test_reset_drain();
    blk_t v, e;
    v = '{4'h5, 4'h3, 4'h7, 4'h1, 4'h0, 4'h2, 4'h6, 4'h4};
    clear_flags();
    load_n(v, N, 1'b0);
    drain_n(3, 1'b0);
    n_tests++;
    if (timeout || got_d.size() != 3 || got_d[0] !== 4'h7 || got_d[1] !== 4'h6 || got_d[2] !== 4'h5) begin
      n_fail++; $display("FAIL rstdrain_prefix: got %0d outputs first=%h want 3 outputs 7,6,5", got_d.size(), got_d.size() > 0 ? got_d[0] : 4'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstdrain_state: got valid=%b data=%h ready=%b want 0 0 1", out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) v[i] = W'(i + 1);
    e = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    clear_flags();
    load_n(v, N, 1'b0);
    drain_n(N, 1'b0);
    n_tests++;
    if (timeout || got_d.size() != N) begin
      n_fail++; $display("FAIL rstdrain_count: got %0d timeout=%0b want %0d", got_d.size(), timeout, N);
    end
    for (int i = 0; i < N && i < got_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== e[i] || got_l[i] !== (i == N - 1)) begin
        n_fail++; $display("FAIL rstdrain_out%0d: got %h last=%0b want %h", i, got_d[i], got_l[i], e[i]);
      end
    end
  endtask

  task automatic test_reset_load();
    blk_t v;
    v = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    clear_flags();
    load_n(v, 4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 4'h2;
    load_n(v, N, 1'b0);
    drain_n(N, 1'b0);
    n_tests++;
    if (timeout || got_d.size() != N) begin
      n_fail++; $display("FAIL rstload_count: got %0d timeout=%0b want %0d", got_d.size(), timeout, N);
    end
    n_tests++;
    if (first_valid_cyc - last_acc_cyc != N) begin
      n_fail++; $display("FAIL rstload_latency: got %0d want %0d", first_valid_cyc - last_acc_cyc, N);
    end
    for (int i = 0; i < N && i < got_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== 4'h2 || got_l[i] !== (i == N - 1)) begin
        n_fail++; $display("FAIL rstload_out%0d: got %h last=%0b want 2", i, got_d[i], got_l[i]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_patterns();
    test_random();
    test_back_to_back();
    test_reset_drain();
    test_reset_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
